// File: rtl/pe_pkg.sv
// Shared types and constants for the output-stationary MAC processing element.
// Saturation bounds are computed at elaboration time by the sat_min/sat_max functions.
package pe_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        FLUSH = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } pe_state_t;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_WEIGHT_W = 16;
    localparam int PROD_W       = DEF_DATA_W + DEF_WEIGHT_W;
    localparam int SAT_MAX_W    = 128;

    // Results are SAT_MAX_W wide; callers truncate to their accumulator width.
    function automatic logic [SAT_MAX_W-1:0] sat_max(input int w, input bit is_signed);
        logic [SAT_MAX_W-1:0] one;
        one = SAT_MAX_W'(1);
        if (is_signed) return (one << (w - 1)) - one;
        return (one << w) - one;
    endfunction

    function automatic logic [SAT_MAX_W-1:0] sat_min(input int w, input bit is_signed);
        logic [SAT_MAX_W-1:0] one;
        one = SAT_MAX_W'(1);
        if (is_signed) return one << (w - 1);
        return '0;
    endfunction

endpackage

// File: rtl/pe_mac_pipe.sv
// Two-stage multiply/accumulate: stage 1 registers the extended product, stage 2 adds it to acc.
// PE_SATURATE_EN clamps stage 2 on overflow and drives a sticky sat flag; otherwise acc wraps.
module pe_mac_pipe
    import pe_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int WEIGHT_W = DEF_WEIGHT_W,
    parameter int ACC_W    = 40,
    parameter int SIGNED   = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                clr_i,
    input  logic                fire_i,
    input  logic [DATA_W-1:0]   a_i,
    input  logic [WEIGHT_W-1:0] b_i,
    output logic [ACC_W-1:0]    acc_o,
    output logic                sat_o
);

    localparam int PW = DATA_W + WEIGHT_W;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] prod_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             v1_q;

    generate
        if (SIGNED != 0) begin : g_signed
            logic signed [PW-1:0] p;
            assign p        = PW'($signed(a_i)) * PW'($signed(b_i));
            assign prod_ext = ACC_W'(p);
        end else begin : g_unsigned
            logic [PW-1:0] p;
            assign p        = PW'(a_i) * PW'(b_i);
            assign prod_ext = ACC_W'(p);
        end
    endgenerate

`ifdef PE_SATURATE_EN
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W, SIGNED != 0));
    localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W, SIGNED != 0));

    logic [ACC_W:0] sum;
    logic           ovf;
    logic           sat_q;

    // One guard bit exposes overflow; the guard bit's sign picks the clamp direction.
    always_comb begin
        sum   = '0;
        ovf   = 1'b0;
        acc_d = '0;
        if (SIGNED != 0) begin
            sum   = {acc_q[ACC_W-1], acc_q} + {prod_q[ACC_W-1], prod_q};
            ovf   = sum[ACC_W] ^ sum[ACC_W-1];
            acc_d = !ovf ? sum[ACC_W-1:0] : (sum[ACC_W] ? ACC_MIN : ACC_MAX);
        end else begin
            sum   = {1'b0, acc_q} + {1'b0, prod_q};
            ovf   = sum[ACC_W];
            acc_d = ovf ? ACC_MAX : sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sat_q <= 1'b0;
        end else if (en_i) begin
            if (clr_i)
                sat_q <= 1'b0;
            else if (v1_q && ovf)
                sat_q <= 1'b1;
        end
    end

    assign sat_o = sat_q;
`else
    assign acc_d = acc_q + prod_q;
    assign sat_o = 1'b0;
`endif

    // Clear drops any in-flight product but still admits a pair fired in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prod_q <= '0;
            v1_q   <= 1'b0;
            acc_q  <= '0;
        end else if (en_i) begin
            v1_q <= fire_i;
            if (fire_i)
                prod_q <= prod_ext;
            if (clr_i)
                acc_q <= '0;
            else if (v1_q)
                acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/pe_os_mac.sv
// Output-stationary systolic MAC PE: forwards operands east/south, accumulates k_len products, unloads via a psum chain.
// gate=0 freezes all state; optional PE_SATURATE_EN clamps the accumulator instead of wrapping.
module pe_os_mac
    import pe_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int WEIGHT_W = DEF_WEIGHT_W,
    parameter int ACC_W    = 40,
    parameter int CNT_W    = 16,
    parameter int SIGNED   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                gate,
    input  logic                start,
    input  logic [CNT_W-1:0]    k_len,
    input  logic [DATA_W-1:0]   f_in,
    input  logic                f_valid_in,
    input  logic [WEIGHT_W-1:0] w_in,
    input  logic                w_valid_in,
    output logic [DATA_W-1:0]   f_out,
    output logic                f_valid_out,
    output logic [WEIGHT_W-1:0] w_out,
    output logic                w_valid_out,
    input  logic                drain_en,
    input  logic [ACC_W-1:0]    psum_in,
    input  logic                psum_valid_in,
    output logic [ACC_W-1:0]    psum_out,
    output logic                psum_valid_out,
    output logic                busy,
    output logic                done,
    output logic                sat_flag
);

    pe_state_t           state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [CNT_W-1:0]    klen_q;
    logic [DATA_W-1:0]   f_out_q;
    logic                f_vld_q;
    logic [WEIGHT_W-1:0] w_out_q;
    logic                w_vld_q;
    logic [ACC_W-1:0]    psum_q;
    logic                psum_vld_q;
    logic [ACC_W-1:0]    acc;
    logic                fire;

    // A start cycle opens the new job, so its pair is judged against the incoming k_len.
    assign fire  = f_valid_in && w_valid_in &&
                   (start ? (k_len != '0) : (state_q == ACCUM && cnt_q != klen_q));
    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            klen_q     <= '0;
            f_out_q    <= '0;
            f_vld_q    <= 1'b0;
            w_out_q    <= '0;
            w_vld_q    <= 1'b0;
            psum_q     <= '0;
            psum_vld_q <= 1'b0;
        end else if (gate) begin
            f_out_q <= f_in;
            f_vld_q <= f_valid_in;
            w_out_q <= w_in;
            w_vld_q <= w_valid_in;
            if (start) begin
                klen_q     <= k_len;
                cnt_q      <= fire ? CNT_W'(1) : '0;
                state_q    <= (fire && k_len == CNT_W'(1)) ? FLUSH : ACCUM;
                psum_q     <= '0;
                psum_vld_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: ;
                    ACCUM: begin
                        if (fire) begin
                            cnt_q <= cnt_d;
                            if (cnt_d == klen_q)
                                state_q <= FLUSH;
                        end else if (cnt_q == klen_q) begin
                            state_q <= FLUSH;
                        end
                    end
                    FLUSH: state_q <= HOLD;
                    HOLD: begin
                        if (drain_en) begin
                            psum_q     <= acc;
                            psum_vld_q <= 1'b1;
                            state_q    <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (drain_en) begin
                            psum_q     <= psum_in;
                            psum_vld_q <= psum_valid_in;
                        end else begin
                            psum_q     <= '0;
                            psum_vld_q <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    pe_mac_pipe #(
        .DATA_W   (DATA_W),
        .WEIGHT_W (WEIGHT_W),
        .ACC_W    (ACC_W),
        .SIGNED   (SIGNED)
    ) u_mac (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (gate),
        .clr_i  (start),
        .fire_i (fire),
        .a_i    (f_in),
        .b_i    (w_in),
        .acc_o  (acc),
        .sat_o  (sat_flag)
    );

    assign f_out          = f_out_q;
    assign f_valid_out    = f_vld_q;
    assign w_out          = w_out_q;
    assign w_valid_out    = w_vld_q;
    assign psum_out       = psum_q;
    assign psum_valid_out = psum_vld_q;
    assign busy           = (state_q == ACCUM) || (state_q == FLUSH);
    assign done           = (state_q == HOLD);

endmodule

// File: tb/tb_pe_os_mac.sv
// Directed bench for pe_os_mac: a 40-bit accumulator instance plus a 32-bit one for overflow behaviour.
module tb_pe_os_mac;

    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, gate, start, drain_en;
    logic [CW-1:0] k_len;
    logic [15:0]   f_in, w_in;
    logic          f_valid_in, w_valid_in;
    logic [39:0]   psum_in;
    logic          psum_valid_in;

    logic [15:0]   f_out, w_out;
    logic          f_valid_out, w_valid_out;
    logic [39:0]   psum_out;
    logic          psum_valid_out, busy, done, sat_flag;

    logic [15:0]   s_f_out, s_w_out;
    logic          s_f_valid_out, s_w_valid_out;
    logic [31:0]   s_psum_in;
    logic [31:0]   s_psum_out;
    logic          s_psum_valid_out, s_busy, s_done, s_sat_flag;

    int total = 0;
    int bad   = 0;

    pe_os_mac #(.DATA_W(16), .WEIGHT_W(16), .ACC_W(40), .CNT_W(CW), .SIGNED(1)) dut (
        .clk(clk), .rst(rst), .gate(gate), .start(start), .k_len(k_len),
        .f_in(f_in), .f_valid_in(f_valid_in), .w_in(w_in), .w_valid_in(w_valid_in),
        .f_out(f_out), .f_valid_out(f_valid_out), .w_out(w_out), .w_valid_out(w_valid_out),
        .drain_en(drain_en), .psum_in(psum_in), .psum_valid_in(psum_valid_in),
        .psum_out(psum_out), .psum_valid_out(psum_valid_out),
        .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    pe_os_mac #(.DATA_W(16), .WEIGHT_W(16), .ACC_W(32), .CNT_W(CW), .SIGNED(1)) u_acc32 (
        .clk(clk), .rst(rst), .gate(gate), .start(start), .k_len(k_len),
        .f_in(f_in), .f_valid_in(f_valid_in), .w_in(w_in), .w_valid_in(w_valid_in),
        .f_out(s_f_out), .f_valid_out(s_f_valid_out), .w_out(s_w_out), .w_valid_out(s_w_valid_out),
        .drain_en(drain_en), .psum_in(s_psum_in), .psum_valid_in(1'b0),
        .psum_out(s_psum_out), .psum_valid_out(s_psum_valid_out),
        .busy(s_busy), .done(s_done), .sat_flag(s_sat_flag)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pair(input logic [15:0] f, input logic [15:0] w);
        f_in = f; w_in = w; f_valid_in = 1'b1; w_valid_in = 1'b1;
        tick();
    endtask

    task automatic no_pair();
        f_valid_in = 1'b0; w_valid_in = 1'b0;
    endtask

    task automatic begin_job(input logic [CW-1:0] k);
        start = 1'b1; k_len = k;
        tick();
        start = 1'b0;
    endtask

    // One drain cycle exposes acc on psum_out; dropping drain_en returns the PE to IDLE.
    task automatic read_acc(output logic [39:0] a, output logic v, output logic [31:0] a32);
        drain_en = 1'b1;
        tick();
        a = psum_out; v = psum_valid_out; a32 = s_psum_out;
        drain_en = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; f_in = 16'h1234; f_valid_in = 1'b1; w_in = 16'h0; w_valid_in = 1'b0;
        tick(); tick();
        total++; if (f_out !== 16'h0 || f_valid_out !== 1'b0) begin bad++; $display("FAIL reset_fwd got f_out=%h v=%b exp 0/0", f_out, f_valid_out); end
        total++; if (psum_out !== 40'h0 || psum_valid_out !== 1'b0) begin bad++; $display("FAIL reset_psum got %h v=%b exp 0/0", psum_out, psum_valid_out); end
        total++; if ({busy, done, sat_flag, w_valid_out} !== 4'b0) begin bad++; $display("FAIL reset_status got busy=%b done=%b sat=%b wv=%b exp all 0", busy, done, sat_flag, w_valid_out); end
        rst = 1'b0;
        tick();
        total++; if (f_out !== 16'h1234 || f_valid_out !== 1'b1) begin bad++; $display("FAIL idle_fwd got f_out=%h v=%b exp 1234/1", f_out, f_valid_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got %b exp 0", busy); end
        no_pair();
        tick();
    endtask

    task automatic test_mac();
        logic [39:0] a; logic v; logic [31:0] a32;
        begin_job(CW'(4));
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mac_busy got %b exp 1", busy); end
        pair(16'd3, 16'd2); pair(16'hFFFF, 16'd5); pair(16'd7, 16'd7); pair(16'd0, 16'd9);
        no_pair();
        total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL mac_flush got done=%b busy=%b exp 0/1", done, busy); end
        tick();
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mac_done got done=%b busy=%b exp 1/0", done, busy); end
        pair(16'h0011, 16'h0022);
        no_pair();
        total++; if (f_out !== 16'h0011 || w_out !== 16'h0022 || w_valid_out !== 1'b1) begin bad++; $display("FAIL mac_fwd5 got f=%h w=%h wv=%b exp 0011/0022/1", f_out, w_out, w_valid_out); end
        read_acc(a, v, a32);
        total++; if (a !== 40'd50 || v !== 1'b1) begin bad++; $display("FAIL mac_acc got %0d v=%b exp 50/1", a, v); end
        total++; if (psum_valid_out !== 1'b0 || psum_out !== 40'h0 || done !== 1'b0) begin bad++; $display("FAIL mac_idle got psum=%h v=%b done=%b exp 0/0/0", psum_out, psum_valid_out, done); end
    endtask

    task automatic test_gate();
        logic [39:0] a; logic v; logic [31:0] a32;
        int n;
        begin_job(CW'(4));
        pair(16'd3, 16'd2); pair(16'hFFFF, 16'd5);
        n = 3;
        gate = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pair(16'd9, 16'd9);
            n++;
            total++; if (f_out !== 16'hFFFF || w_out !== 16'd5 || f_valid_out !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL gate_freeze%0d got f=%h w=%h fv=%b busy=%b exp ffff/0005/1/1", i, f_out, w_out, f_valid_out, busy); end
        end
        gate = 1'b1;
        pair(16'd7, 16'd7); pair(16'd0, 16'd9);
        no_pair();
        n += 2;
        for (int i = 0; i < 20 && done !== 1'b1; i++) begin
            tick();
            n++;
        end
        total++; if (done !== 1'b1 || n != 9) begin bad++; $display("FAIL gate_done got done=%b ticks=%0d exp 1/9", done, n); end
        read_acc(a, v, a32);
        total++; if (a !== 40'd50) begin bad++; $display("FAIL gate_acc got %0d exp 50", a); end
    endtask

    task automatic test_drain();
        begin_job(CW'(1));
        pair(16'd5, 16'd6);
        no_pair();
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL drain_ready got done=%b exp 1", done); end
        drain_en = 1'b1; psum_in = 40'd0; psum_valid_in = 1'b0;
        tick();
        total++; if (psum_out !== 40'd30 || psum_valid_out !== 1'b1) begin bad++; $display("FAIL drain_0 got %0d v=%b exp 30/1", psum_out, psum_valid_out); end
        psum_in = 40'd20; psum_valid_in = 1'b1;
        tick();
        total++; if (psum_out !== 40'd20 || psum_valid_out !== 1'b1) begin bad++; $display("FAIL drain_1 got %0d v=%b exp 20/1", psum_out, psum_valid_out); end
        psum_in = 40'd10;
        tick();
        total++; if (psum_out !== 40'd10 || psum_valid_out !== 1'b1) begin bad++; $display("FAIL drain_2 got %0d v=%b exp 10/1", psum_out, psum_valid_out); end
        drain_en = 1'b0; psum_in = 40'd0; psum_valid_in = 1'b0;
        tick();
        total++; if (psum_valid_out !== 1'b0 || psum_out !== 40'd0 || done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL drain_end got %0d v=%b done=%b busy=%b exp 0/0/0/0", psum_out, psum_valid_out, done, busy); end
    endtask

    task automatic test_restart();
        logic [39:0] a; logic v; logic [31:0] a32;
        begin_job(CW'(4));
        pair(16'd1, 16'd1); pair(16'd2, 16'd2);
        start = 1'b1; k_len = CW'(1);
        pair(16'd4, 16'd4);
        start = 1'b0;
        no_pair();
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL restart_flush got busy=%b done=%b exp 1/0", busy, done); end
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL restart_done got %b exp 1", done); end
        read_acc(a, v, a32);
        total++; if (a !== 40'd16) begin bad++; $display("FAIL restart_acc got %0d exp 16", a); end
        start = 1'b1; k_len = CW'(0);
        pair(16'd7, 16'd7);
        start = 1'b0;
        no_pair();
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL k0_accum got busy=%b done=%b exp 1/0", busy, done); end
        tick(); tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL k0_done got %b exp 1", done); end
        read_acc(a, v, a32);
        total++; if (a !== 40'd0) begin bad++; $display("FAIL k0_acc got %0d exp 0", a); end
    endtask

    task automatic test_saturate();
        logic [39:0] a; logic v; logic [31:0] a32;
        logic [31:0] exp32;
        logic        exp_sat;
`ifdef PE_SATURATE_EN
        exp32 = 32'h7FFF_FFFF; exp_sat = 1'b1;
`else
        exp32 = 32'hBFFD_0003; exp_sat = 1'b0;
`endif
        begin_job(CW'(3));
        pair(16'h7FFF, 16'h7FFF); pair(16'h7FFF, 16'h7FFF); pair(16'h7FFF, 16'h7FFF);
        no_pair();
        tick();
        total++; if (s_done !== 1'b1 || s_sat_flag !== exp_sat) begin bad++; $display("FAIL sat_flag got done=%b sat=%b exp 1/%b", s_done, s_sat_flag, exp_sat); end
        total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL sat_wide_flag got %b exp 0", sat_flag); end
        read_acc(a, v, a32);
        total++; if (a32 !== exp32) begin bad++; $display("FAIL sat_acc32 got %h exp %h", a32, exp32); end
        total++; if (a !== 40'h00_BFFD_0003) begin bad++; $display("FAIL sat_acc40 got %h exp 00bffd0003", a); end
        begin_job(CW'(0));
        total++; if (s_sat_flag !== 1'b0) begin bad++; $display("FAIL sat_clear got %b exp 0", s_sat_flag); end
        tick(); tick();
    endtask

    initial begin
        rst = 1'b1; gate = 1'b1; start = 1'b0; drain_en = 1'b0; k_len = '0;
        f_in = '0; w_in = '0; f_valid_in = 1'b0; w_valid_in = 1'b0;
        psum_in = '0; psum_valid_in = 1'b0; s_psum_in = '0;
        test_reset();
        test_mac();
        test_gate();
        test_drain();
        test_restart();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
